mcycle_ctrl: RTL and testbench
==============================

Name: mcycle_ctrl

Overview:
- Multi-cycle successor to the single-cycle main decoder of the MIPS teaching CPU.
- Sequences every instruction through the fetch, decode, execute, memory and write-back states, one state per clock.
- Drives the same datapath selects as the single-cycle decoder, plus PC/IR write enables and the ALU source selects.
- Adds beq, j and a memory access that holds for a parameterised number of cycles.

Parameters:
- ALU_OP_W, 3: width of ALU_OP; must be ≥3. Only the low 3 bits are coded; upper bits are 0.
- MEM_LAT, 1: cycles spent in S_MEM (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- op_code  in  6  instruction bits [31:26], from the IR.
- funct  in  6  instruction bits [5:0], from the IR.
- zero  in  1  ALU zero flag.
- PC_Write  out  1  PC load enable.
- IR_Write  out  1  IR load enable.
- Write_Reg  out  1  register-file write enable.
- Mem_Write  out  1  data-memory write.
- Mem_Read  out  1  data-memory read.
- ALU_OP  out  ALU_OP_W  ALU function.
- rd_rt_s  out  1  destination select: 1 = rt.
- imm_s  out  1  immediate extension: 1 = sign-extend.
- rt_imm_s  out  1  ALU B operand: 1 = immediate.
- alu_mem_s  out  1  write-back data: 1 = memory.
- alu_a_s  out  1  ALU A operand: 0 = rs, 1 = PC.
- pc_s  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- illegal  out  1  trap flag (optional feature).
- state  out  3  current state, for debug.

Behaviour:
- Encoding: the 3-bit state register holds S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_TRAP=5.
- Reset: state←S_IF, wait counter←0, latched decode←0. All strobes (PC_Write, IR_Write, Write_Reg, Mem_Write, Mem_Read) are gated low while rst=1. Reset mid-instruction abandons the instruction and produces no strobe on that cycle.
- Strobe outputs are combinational from state, the latched decode and zero. State and decode are registered.
- S_IF: IR_Write=1, PC_Write=1, pc_s=0 → S_ID.
- S_ID: op_code/funct are decoded and latched into the class, ALU_OP and select registers. The latched values drive the outputs until the next S_ID, so IR changes have no effect.
  - R-type, addi, andi, xori, sltiu, lw, sw, beq → S_EX.
  - j (op 000010): PC_Write=1, pc_s=2 → S_IF.
  - Any other op_code, or an R-type funct outside the coded set, is illegal.
- ALU_OP coding: and 000, or 001, xor 010, nor 011, add 100, sub 101, sltu 110, sllv 111.
- Select decode: identical to the single-cycle decoder for the ALU-immediate, lw and sw instructions.
- beq (op 000100): ALU_OP=101, rt_imm_s=0.
- S_EX: the ALU operates.
  - beq: PC_Write=zero, pc_s=1 → S_IF.
  - lw/sw: counter←MEM_LAT−1 → S_MEM.
  - Others → S_WB.
- S_MEM: Mem_Read=1 (lw) or Mem_Write=1 (sw) on every cycle in the state.
  - Counter decrements each cycle.
  - Exit on the cycle the counter equals 0: sw → S_IF, lw → S_WB.
  - With MEM_LAT=1 the state lasts exactly 1 cycle.
- S_WB: Write_Reg=1 for exactly one cycle. alu_mem_s=1 for lw. → S_IF.
- Cycle counts:
  - R-type / ALU-immediate: 4.
  - lw: 4+MEM_LAT.
  - sw: 3+MEM_LAT.
  - beq: 3.
  - j: 2.
- Write_Reg and Mem_Write are never high in the same cycle. Write_Reg is never high outside S_WB.

Optional Feature:
- Macro MCTRL_TRAP_EN.
- Defined: an illegal instruction in S_ID → S_TRAP. In S_TRAP illegal=1, all strobes are 0, and the block stays there until rst.
- Undefined: an illegal instruction executes as a NOP (S_ID → S_IF, no strobes); illegal is tied to 0 and S_TRAP is unreachable.

Decomposition:
- Package mcycle_pkg holds:
  - State encodings.
  - ALU_OP codes.
  - op_code constants: R=000000, J=000010, BEQ=000100, ADDI=001000, SLTIU=001011, ANDI=001100, XORI=001110, LW=100011, SW=101011.
  - funct constants.
- Sub-module mcycle_op_decode: purely combinational op/funct → {class, ALU_OP, select bits, legal}. Its outputs are latched by the FSM in S_ID.

Test Plan:
- Reset, then R-type add (op 0, funct 100000) → states 0,1,2,4; ALU_OP=100 from S_ID on; Write_Reg=1 only in cycle 4; rd_rt_s=0.
- lw with MEM_LAT=3 → 7 cycles; Mem_Read high for exactly 3 cycles; then Write_Reg=1 with alu_mem_s=1, rd_rt_s=1, imm_s=1.
- sw with MEM_LAT=1 → 4 cycles; Mem_Write=1 for exactly 1 cycle; Write_Reg stays 0 throughout.
- beq with zero=1 → PC_Write=1, pc_s=1 in S_EX. Repeat with zero=0 → PC_Write=0. Both take 3 cycles.
- j (op 000010) → PC_Write=1, pc_s=2 in S_ID; back in S_IF next cycle. Also: rst asserted in S_MEM of a sw → Mem_Write=0 that cycle; state=S_IF next cycle.
- Illegal op 111111:
  - With MCTRL_TRAP_EN: illegal=1 and state=5 held for 20 cycles until rst.
  - Without: returns to S_IF after S_ID with no strobes.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// states, instruction classes, ALU codes, op_code and funct values.
package mcycle_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NOP = 3'd0,
        CL_ALU = 3'd1,
        CL_LW  = 3'd2,
        CL_SW  = 3'd3,
        CL_BEQ = 3'd4,
        CL_J   = 3'd5
    } cls_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLLV = 6'b000100;

    typedef struct packed {
        cls_t       cls;
        logic [2:0] alu;
        logic       rd_rt_s;
        logic       imm_s;
        logic       rt_imm_s;
        logic       alu_mem_s;
    } dec_t;

endpackage

// File: rtl/mcycle_op_decode.sv
// Combinational op_code/funct decoder; the FSM latches its outputs
// during S_ID so later IR changes cannot disturb the instruction.
module mcycle_op_decode
    import mcycle_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic [2:0] alu_op,
    output logic       rd_rt_s,
    output logic       imm_s,
    output logic       rt_imm_s,
    output logic       alu_mem_s,
    output logic       legal
);

    always_comb begin
        cls       = CL_NOP;
        alu_op    = ALU_AND;
        rd_rt_s   = 1'b0;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        alu_mem_s = 1'b0;
        legal     = 1'b1;
        unique case (op_code)
            OP_R: begin
                cls = CL_ALU;
                unique case (funct)
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    F_NOR:   alu_op = ALU_NOR;
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_SLTU:  alu_op = ALU_SLTU;
                    F_SLLV:  alu_op = ALU_SLLV;
                    default: begin
                        cls   = CL_NOP;
                        legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTIU: begin
                cls      = CL_ALU;
                alu_op   = (op_code == OP_ADDI) ? ALU_ADD : ALU_SLTU;
                rd_rt_s  = 1'b1;
                imm_s    = 1'b1;
                rt_imm_s = 1'b1;
            end
            // logical immediates are zero-extended
            OP_ANDI, OP_XORI: begin
                cls      = CL_ALU;
                alu_op   = (op_code == OP_ANDI) ? ALU_AND : ALU_XOR;
                rd_rt_s  = 1'b1;
                rt_imm_s = 1'b1;
            end
            OP_LW, OP_SW: begin
                cls       = (op_code == OP_LW) ? CL_LW : CL_SW;
                alu_op    = ALU_ADD;
                rd_rt_s   = 1'b1;
                imm_s     = 1'b1;
                rt_imm_s  = 1'b1;
                alu_mem_s = (op_code == OP_LW);
            end
            OP_BEQ: begin
                cls    = CL_BEQ;
                alu_op = ALU_SUB;
                imm_s  = 1'b1;
            end
            OP_J:    cls = CL_J;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB, one state per clock).
// Define MCTRL_TRAP_EN to trap on illegal instructions instead of NOPing.
module mcycle_ctrl
    import mcycle_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op_code,
    input  logic [5:0]          funct,
    input  logic                zero,
    output logic                PC_Write,
    output logic                IR_Write,
    output logic                Write_Reg,
    output logic                Mem_Write,
    output logic                Mem_Read,
    output logic [ALU_OP_W-1:0] ALU_OP,
    output logic                rd_rt_s,
    output logic                imm_s,
    output logic                rt_imm_s,
    output logic                alu_mem_s,
    output logic                alu_a_s,
    output logic [1:0]          pc_s,
    output logic                illegal,
    output logic [2:0]          state
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     cur, nxt;
    dec_t       dec_d, dec_q, dec;
    logic [3:0] cnt_q;
    logic [2:0] cls_w, alu_w;
    logic       rd_rt_w, imm_w, rt_imm_w, alu_mem_w, legal_w;
    logic       pcw, irw, wr, mw, mr;

    mcycle_op_decode u_dec (
        .op_code   (op_code),
        .funct     (funct),
        .cls       (cls_w),
        .alu_op    (alu_w),
        .rd_rt_s   (rd_rt_w),
        .imm_s     (imm_w),
        .rt_imm_s  (rt_imm_w),
        .alu_mem_s (alu_mem_w),
        .legal     (legal_w)
    );

    assign dec_d = '{
        cls:       cls_t'(cls_w),
        alu:       alu_w,
        rd_rt_s:   rd_rt_w,
        imm_s:     imm_w,
        rt_imm_s:  rt_imm_w,
        alu_mem_s: alu_mem_w
    };

    // live decode in S_ID, latched copy everywhere else
    assign dec = (cur == S_ID) ? dec_d : dec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= S_IF;
            cnt_q <= '0;
            dec_q <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_ID)
                dec_q <= dec_d;
            if (cur == S_EX)
                cnt_q <= LAT_M1;
            else if (cur == S_MEM && cnt_q != '0)
                cnt_q <= cnt_q - 4'd1;
        end
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                if (!legal_w) begin
`ifdef MCTRL_TRAP_EN
                    nxt = S_TRAP;
`else
                    nxt = S_IF;
`endif
                end else if (dec_d.cls == CL_J) begin
                    nxt = S_IF;
                end else begin
                    nxt = S_EX;
                end
            end
            S_EX: begin
                unique case (dec_q.cls)
                    CL_BEQ:       nxt = S_IF;
                    CL_LW, CL_SW: nxt = S_MEM;
                    default:      nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (cnt_q == '0)
                    nxt = (dec_q.cls == CL_LW) ? S_WB : S_IF;
            end
            S_WB: nxt = S_IF;
`ifdef MCTRL_TRAP_EN
            S_TRAP: nxt = S_TRAP;
`endif
            default: nxt = S_IF;
        endcase
    end

    always_comb begin
        pcw     = 1'b0;
        irw     = 1'b0;
        wr      = 1'b0;
        mw      = 1'b0;
        mr      = 1'b0;
        pc_s    = 2'd0;
        alu_a_s = 1'b0;
        unique case (cur)
            S_IF: begin
                irw     = 1'b1;
                pcw     = 1'b1;
                alu_a_s = 1'b1;
            end
            S_ID: begin
                if (legal_w && dec_d.cls == CL_J) begin
                    pcw  = 1'b1;
                    pc_s = 2'd2;
                end
            end
            S_EX: begin
                if (dec_q.cls == CL_BEQ) begin
                    pcw  = zero;
                    pc_s = 2'd1;
                end
            end
            S_MEM: begin
                mr = (dec_q.cls == CL_LW);
                mw = (dec_q.cls == CL_SW);
            end
            S_WB:    wr = 1'b1;
            default: ;
        endcase
    end

    // reset abandons the instruction with no strobe that cycle
    assign PC_Write  = pcw & ~rst;
    assign IR_Write  = irw & ~rst;
    assign Write_Reg = wr  & ~rst;
    assign Mem_Write = mw  & ~rst;
    assign Mem_Read  = mr  & ~rst;

    always_comb begin
        ALU_OP      = '0;
        ALU_OP[2:0] = dec.alu;
    end

    assign rd_rt_s   = dec.rd_rt_s;
    assign imm_s     = dec.imm_s;
    assign rt_imm_s  = dec.rt_imm_s;
    assign alu_mem_s = dec.alu_mem_s;
    assign state     = cur;

`ifdef MCTRL_TRAP_EN
    assign illegal = (cur == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Bench for mcycle_ctrl: two instances (MEM_LAT=3, MEM_LAT=1/ALU_OP_W=4)
// checked cycle by cycle against a per-instruction trace model.
module tb_mcycle_ctrl;

    localparam logic [2:0] K_ILL = 3'd0;
    localparam logic [2:0] K_ALU = 3'd1;
    localparam logic [2:0] K_LW  = 3'd2;
    localparam logic [2:0] K_SW  = 3'd3;
    localparam logic [2:0] K_BEQ = 3'd4;
    localparam logic [2:0] K_J   = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] alu;
        logic       rd_rt;
        logic       imm;
        logic       immv;
        logic       rti;
        logic       am;
    } ref_t;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic       irw;
        logic       wr;
        logic       mw;
        logic       mr;
        logic       ill;
        logic [1:0] pcs;
        logic       pcs_chk;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code, funct;
    logic       zero;
    logic       sel;

    logic       pcw0, irw0, wr0, mw0, mr0, rdrt0, imm0, rti0, am0, aa0, ill0;
    logic       pcw1, irw1, wr1, mw1, mr1, rdrt1, imm1, rti1, am1, aa1, ill1;
    logic [2:0] alu0, st0, st1;
    logic [3:0] alu1;
    logic [1:0] pcs0, pcs1;

    logic       o_pcw, o_irw, o_wr, o_mw, o_mr, o_rdrt, o_imm, o_rti, o_am, o_ill;
    logic [2:0] o_st;
    logic [3:0] o_alu;
    logic [1:0] o_pcs;

    int   tests = 0;
    int   fails = 0;
    int   ninstr = 0;
    cyc_t tr[$];

    always #5 clk = ~clk;

    mcycle_ctrl #(.ALU_OP_W(3), .MEM_LAT(3)) dut0 (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .zero(zero),
        .PC_Write(pcw0), .IR_Write(irw0), .Write_Reg(wr0),
        .Mem_Write(mw0), .Mem_Read(mr0), .ALU_OP(alu0),
        .rd_rt_s(rdrt0), .imm_s(imm0), .rt_imm_s(rti0), .alu_mem_s(am0),
        .alu_a_s(aa0), .pc_s(pcs0), .illegal(ill0), .state(st0)
    );

    mcycle_ctrl #(.ALU_OP_W(4), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .zero(zero),
        .PC_Write(pcw1), .IR_Write(irw1), .Write_Reg(wr1),
        .Mem_Write(mw1), .Mem_Read(mr1), .ALU_OP(alu1),
        .rd_rt_s(rdrt1), .imm_s(imm1), .rt_imm_s(rti1), .alu_mem_s(am1),
        .alu_a_s(aa1), .pc_s(pcs1), .illegal(ill1), .state(st1)
    );

    always_comb begin
        if (sel) begin
            o_pcw = pcw1; o_irw = irw1; o_wr = wr1; o_mw = mw1; o_mr = mr1;
            o_rdrt = rdrt1; o_imm = imm1; o_rti = rti1; o_am = am1;
            o_ill = ill1; o_st = st1; o_alu = alu1; o_pcs = pcs1;
        end else begin
            o_pcw = pcw0; o_irw = irw0; o_wr = wr0; o_mw = mw0; o_mr = mr0;
            o_rdrt = rdrt0; o_imm = imm0; o_rti = rti0; o_am = am0;
            o_ill = ill0; o_st = st0; o_alu = {1'b0, alu0}; o_pcs = pcs0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic string tg(input string n, input int k);
        return $sformatf("%s d%0d i%0d c%0d", n, sel, ninstr, k);
    endfunction

    function automatic ref_t ref_dec(input logic [5:0] op, input logic [5:0] fn);
        ref_t r;
        r = '0;
        case (op)
            6'b000000: begin
                r.kind = K_ALU;
                case (fn)
                    6'b100100: r.alu = 4'd0;
                    6'b100101: r.alu = 4'd1;
                    6'b100110: r.alu = 4'd2;
                    6'b100111: r.alu = 4'd3;
                    6'b100000: r.alu = 4'd4;
                    6'b100010: r.alu = 4'd5;
                    6'b101011: r.alu = 4'd6;
                    6'b000100: r.alu = 4'd7;
                    default:   r.kind = K_ILL;
                endcase
            end
            6'b001000: r = '{K_ALU, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            6'b001011: r = '{K_ALU, 4'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            6'b001100: r = '{K_ALU, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            6'b001110: r = '{K_ALU, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            6'b100011: r = '{K_LW,  4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            6'b101011: r = '{K_SW,  4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            6'b000100: r = '{K_BEQ, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            6'b000010: r.kind = K_J;
            default:   r.kind = K_ILL;
        endcase
        return r;
    endfunction

    task automatic build(input ref_t r, input logic z, input int lat);
        cyc_t c;
        tr.delete();
        c = '0; c.st = 3'd0; c.pcw = 1'b1; c.irw = 1'b1; c.pcs_chk = 1'b1;
        tr.push_back(c);
        c = '0; c.st = 3'd1;
        if (r.kind == K_J) begin
            c.pcw = 1'b1; c.pcs = 2'd2; c.pcs_chk = 1'b1;
        end
        tr.push_back(c);
        if (r.kind == K_ILL) begin
`ifdef MCTRL_TRAP_EN
            for (int i = 0; i < 20; i++) begin
                c = '0; c.st = 3'd5; c.ill = 1'b1;
                tr.push_back(c);
            end
`endif
            return;
        end
        if (r.kind == K_J)
            return;
        c = '0; c.st = 3'd2;
        if (r.kind == K_BEQ) begin
            c.pcw = z; c.pcs = 2'd1; c.pcs_chk = 1'b1;
        end
        tr.push_back(c);
        if (r.kind == K_BEQ)
            return;
        if (r.kind == K_LW || r.kind == K_SW) begin
            for (int i = 0; i < lat; i++) begin
                c = '0; c.st = 3'd3;
                c.mr = (r.kind == K_LW);
                c.mw = (r.kind == K_SW);
                tr.push_back(c);
            end
        end
        if (r.kind != K_SW) begin
            c = '0; c.st = 3'd4; c.wr = 1'b1;
            tr.push_back(c);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input int lat);
        ref_t r;
        r = ref_dec(op, fn);
        op_code = op;
        funct   = fn;
        zero    = z;
        build(r, z, lat);
        ninstr++;
        foreach (tr[k]) begin
            @(negedge clk);
            chk(tg("state", k), 8'(o_st), 8'(tr[k].st));
            chk(tg("PC_Write", k), 8'(o_pcw), 8'(tr[k].pcw));
            chk(tg("IR_Write", k), 8'(o_irw), 8'(tr[k].irw));
            chk(tg("Write_Reg", k), 8'(o_wr), 8'(tr[k].wr));
            chk(tg("Mem_Write", k), 8'(o_mw), 8'(tr[k].mw));
            chk(tg("Mem_Read", k), 8'(o_mr), 8'(tr[k].mr));
            chk(tg("illegal", k), 8'(o_ill), 8'(tr[k].ill));
            if (tr[k].pcs_chk)
                chk(tg("pc_s", k), 8'(o_pcs), 8'(tr[k].pcs));
            if (k >= 1 && r.kind != K_ILL && r.kind != K_J) begin
                chk(tg("ALU_OP", k), 8'(o_alu), 8'(r.alu));
                chk(tg("rt_imm_s", k), 8'(o_rti), 8'(r.rti));
                if (r.immv)
                    chk(tg("imm_s", k), 8'(o_imm), 8'(r.imm));
                if (r.kind == K_ALU || r.kind == K_LW) begin
                    chk(tg("rd_rt_s", k), 8'(o_rdrt), 8'(r.rd_rt));
                    chk(tg("alu_mem_s", k), 8'(o_am), 8'(r.am));
                end
            end
            @(posedge clk);
            #1;
            // IR may change after decode; latched controls must hold
            if (k == 1) begin
                op_code = 6'($urandom);
                funct   = 6'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(tg("rst_state", 0), 8'(o_st), 8'd0);
        chk(tg("rst_PC_Write", 0), 8'(o_pcw), 8'd0);
        chk(tg("rst_IR_Write", 0), 8'(o_irw), 8'd0);
        chk(tg("rst_Write_Reg", 0), 8'(o_wr), 8'd0);
        chk(tg("rst_Mem_Write", 0), 8'(o_mw), 8'd0);
        chk(tg("rst_Mem_Read", 0), 8'(o_mr), 8'd0);
        chk(tg("rst_ALU_OP", 0), 8'(o_alu), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_run(input int lat);
        logic [5:0] op, fn;
        int         pick;
        pick = $urandom_range(0, 9);
        fn   = 6'($urandom);
        case (pick)
            0: begin
                op = 6'b000000;
                case ($urandom_range(0, 7))
                    0: fn = 6'b100100;
                    1: fn = 6'b100101;
                    2: fn = 6'b100110;
                    3: fn = 6'b100111;
                    4: fn = 6'b100000;
                    5: fn = 6'b100010;
                    6: fn = 6'b101011;
                    default: fn = 6'b000100;
                endcase
            end
            1: op = 6'b001000;
            2: op = 6'b001100;
            3: op = 6'b001110;
            4: op = 6'b001011;
            5: op = 6'b100011;
            6: op = 6'b101011;
            7: op = 6'b000100;
            8: op = 6'b000010;
`ifdef MCTRL_TRAP_EN
            default: op = 6'b100011;
`else
            default: op = 6'b111111;
`endif
        endcase
        run(op, fn, 1'($urandom), lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel     = 1'b0;
        rst     = 1'b1;
        op_code = '0;
        funct   = '0;
        zero    = 1'b0;
        @(posedge clk);
        #1;

        do_reset();
        run(6'b000000, 6'b100000, 1'b0, 3);
        run(6'b100011, 6'b000000, 1'b0, 3);
        run(6'b101011, 6'b000000, 1'b0, 3);
        run(6'b000100, 6'b000000, 1'b1, 3);
        run(6'b000100, 6'b000000, 1'b0, 3);
        run(6'b000010, 6'b000000, 1'b0, 3);
        run(6'b001100, 6'b000000, 1'b0, 3);
        for (int i = 0; i < 40; i++)
            rand_run(3);

        // reset during the first S_MEM cycle of a sw
        op_code = 6'b101011;
        zero    = 1'b0;
        ninstr++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk(tg("midrst_state", 3), 8'(o_st), 8'd3);
        chk(tg("midrst_Mem_Write", 3), 8'(o_mw), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(tg("midrst_next_state", 4), 8'(o_st), 8'd0);
        chk(tg("midrst_IR_Write", 4), 8'(o_irw), 8'd1);
        @(posedge clk); #1;

        sel = 1'b1;
        do_reset();
        run(6'b101011, 6'b000000, 1'b0, 1);
        run(6'b100011, 6'b000000, 1'b0, 1);
        run(6'b000000, 6'b100111, 1'b0, 1);
        for (int i = 0; i < 30; i++)
            rand_run(1);

        sel = 1'b0;
        do_reset();
        run(6'b111111, 6'b000000, 1'b0, 3);
`ifdef MCTRL_TRAP_EN
        do_reset();
`else
        run(6'b000000, 6'b000000, 1'b0, 3);
`endif
        run(6'b000000, 6'b100010, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
